// File: rtl/waveform_sequencer.sv
// Sample-rate sequencer and configuration controller for the waveform generator.
// Drives the generator's next-data strobe, gates config changes to sample boundaries, muxes one channel out.
module waveform_sequencer #(
  parameter int unsigned N_FRAC  = 7,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [N_FRAC:0]   cfg_phase_i,
  input  logic [N_FRAC:0]   cfg_amplitude_i,
  input  logic [1:0]        cfg_sel_i,
  input  logic [DIV_W-1:0]  cfg_divider_i,
  input  logic              cfg_load_i,
  output logic              cfg_pending_o,
  output logic [N_FRAC:0]   gen_phase_o,
  output logic [N_FRAC:0]   gen_amplitude_o,
  output logic              gen_next_data_strobe_o,
  input  logic [N_FRAC:0]   gen_sawtooth_i,
  input  logic              gen_sawtooth_valid_i,
  input  logic [N_FRAC:0]   gen_triangle_i,
  input  logic              gen_triangle_valid_i,
  input  logic [N_FRAC:0]   gen_square_i,
  input  logic              gen_square_valid_i,
  output logic [N_FRAC:0]   data_o,
  output logic              data_valid_strobe_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic              overrun_o
);

  localparam int unsigned W      = N_FRAC + 1;
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] SEL_SAW  = 2'd0;
  localparam logic [1:0] SEL_TRI  = 2'd1;
  localparam logic [1:0] SEL_SQR  = 2'd2;
  localparam logic [1:0] SEL_MUTE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [W-1:0]      sh_phase_q, sh_phase_d;
  logic [W-1:0]      sh_amp_q, sh_amp_d;
  logic [1:0]        sh_sel_q, sh_sel_d;
  logic [DIV_W-1:0]  sh_div_q, sh_div_d;
  logic              pending_q, pending_d;

  logic [1:0]        sel_q, sel_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [W-1:0]      phase_q, phase_d;
  logic [W-1:0]      amp_q, amp_d;

  logic              strobe_q, strobe_d;
  logic [W-1:0]      hold_q, hold_d;
  logic [W-1:0]      data_q, data_d;
  logic              dvs_q, dvs_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;

  logic              apply_c;
  logic              tick_c;
  logic              sel_valid_c;
  logic [W-1:0]      sel_data_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      sh_phase_q <= '0;
      sh_amp_q   <= '0;
      sh_sel_q   <= '0;
      sh_div_q   <= '0;
      pending_q  <= 1'b0;
      sel_q      <= '0;
      div_q      <= '0;
      phase_q    <= '0;
      amp_q      <= '0;
      strobe_q   <= 1'b0;
      hold_q     <= '0;
      data_q     <= '0;
      dvs_q      <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      sh_phase_q <= sh_phase_d;
      sh_amp_q   <= sh_amp_d;
      sh_sel_q   <= sh_sel_d;
      sh_div_q   <= sh_div_d;
      pending_q  <= pending_d;
      sel_q      <= sel_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      amp_q      <= amp_d;
      strobe_q   <= strobe_d;
      hold_q     <= hold_d;
      data_q     <= data_d;
      dvs_q      <= dvs_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  // Shadow capture and apply; a load coinciding with apply is forwarded straight to the active set.
  always_comb begin
    apply_c    = (state_q == ST_IDLE) && pending_q;
    sh_phase_d = sh_phase_q;
    sh_amp_d   = sh_amp_q;
    sh_sel_d   = sh_sel_q;
    sh_div_d   = sh_div_q;
    pending_d  = pending_q;
    sel_d      = sel_q;
    div_d      = div_q;
    phase_d    = phase_q;
    amp_d      = amp_q;
    if (cfg_load_i) begin
      sh_phase_d = cfg_phase_i;
      sh_amp_d   = cfg_amplitude_i;
      sh_sel_d   = cfg_sel_i;
      sh_div_d   = cfg_divider_i;
      pending_d  = 1'b1;
    end
    if (apply_c) begin
      phase_d   = cfg_load_i ? cfg_phase_i     : sh_phase_q;
      amp_d     = cfg_load_i ? cfg_amplitude_i : sh_amp_q;
      sel_d     = cfg_load_i ? cfg_sel_i       : sh_sel_q;
      div_d     = cfg_load_i ? cfg_divider_i   : sh_div_q;
      pending_d = 1'b0;
    end
  end

  // Sample-rate divider.
  always_comb begin
    tick_c = enable_i && (cnt_q == div_q);
    cnt_d  = cnt_q + DIV_W'(1);
    if (!enable_i || tick_c || apply_c) begin
      cnt_d = '0;
    end
  end

  // Only the selected channel's valid is ever seen by the FSM.
  always_comb begin
    sel_valid_c = 1'b0;
    sel_data_c  = '0;
    case (sel_q)
      SEL_SAW: begin
        sel_valid_c = gen_sawtooth_valid_i;
        sel_data_c  = gen_sawtooth_i;
      end
      SEL_TRI: begin
        sel_valid_c = gen_triangle_valid_i;
        sel_data_c  = gen_triangle_i;
      end
      SEL_SQR: begin
        sel_valid_c = gen_square_valid_i;
        sel_data_c  = gen_square_i;
      end
      default: begin
        sel_valid_c = 1'b0;
        sel_data_c  = '0;
      end
    endcase
  end

  // Sample FSM: next state plus registered output values.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    hold_d    = hold_q;
    data_d    = data_q;
    dvs_d     = 1'b0;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_c && !apply_c) begin
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (sel_q == SEL_MUTE) begin
          hold_d  = '0;
          state_d = ST_OUTPUT;
        end else begin
          wait_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sel_valid_c) begin
          hold_d  = sel_data_c;
          state_d = ST_OUTPUT;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_OUTPUT: begin
        data_d  = hold_q;
        dvs_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A tick that arrives mid-sample is dropped and flagged.
    if (tick_c && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
    strobe_d = (state_d == ST_STROBE);
    busy_d   = (state_d != ST_IDLE);
  end

  assign cfg_pending_o          = pending_q;
  assign gen_phase_o            = phase_q;
  assign gen_amplitude_o        = amp_q;
  assign gen_next_data_strobe_o = strobe_q;
  assign data_o                 = data_q;
  assign data_valid_strobe_o    = dvs_q;
  assign busy_o                 = busy_q;
  assign timeout_o              = timeout_q;
  assign overrun_o              = overrun_q;

endmodule

// File: doc/waveform_sequencer.md
Name: waveform_sequencer

Overview:
- Sequencer and configuration controller for the triangle/sawtooth/square generator top.
- Produces the generator's next-data strobe at a programmable sample rate and holds phase/amplitude stable during each sample.
- Applies new configuration only at sample boundaries.
- Selects one waveform channel, registers it as a single output stream, and flags timeout and overrun faults.

Parameters:
- N_FRAC, 7, fractional bits; sample width is N_FRAC+1, signed.
- DIV_W, 16, width of the sample-rate divider.
- TIMEOUT, 15, maximum cycles in WAIT before the sample is aborted (must be ≥1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- enable_i  in  1  run sample ticks; 0 = divider held at 0, no new samples
- cfg_phase_i  in  N_FRAC+1  signed phase increment (shadow input)
- cfg_amplitude_i  in  N_FRAC+1  signed amplitude/threshold (shadow input)
- cfg_sel_i  in  2  0 sawtooth, 1 triangle, 2 square, 3 mute
- cfg_divider_i  in  DIV_W  sample period minus 1, in clocks (shadow input)
- cfg_load_i  in  1  one-cycle pulse; captures all cfg_* into shadow registers
- cfg_pending_o  out  1  shadow holds values not yet applied
- gen_phase_o  out  N_FRAC+1  to generator phase_i
- gen_amplitude_o  out  N_FRAC+1  to generator amplitude_i
- gen_next_data_strobe_o  out  1  to generator next_data_strobe_i
- gen_sawtooth_i / gen_sawtooth_valid_i  in  N_FRAC+1 / 1  generator sawtooth output and its valid strobe
- gen_triangle_i / gen_triangle_valid_i  in  N_FRAC+1 / 1  generator triangle output and its valid strobe
- gen_square_i / gen_square_valid_i  in  N_FRAC+1 / 1  generator square output and its valid strobe
- data_o  out  N_FRAC+1  selected sample, registered
- data_valid_strobe_o  out  1  one-cycle pulse, data_o is new
- busy_o  out  1  FSM not in IDLE
- timeout_o  out  1  sticky; cleared only by reset
- overrun_o  out  1  sticky; cleared only by reset

Behaviour:
- Reset values: all outputs 0; shadow and active registers 0; FSM = IDLE; divider count = 0; cfg_pending_o = 0.
- Divider:
  - Count increments each cycle while enable_i = 1.
  - When count equals the active divider, tick = 1 and count returns to 0.
  - enable_i = 0 forces count to 0 with no tick.
  - Divider 0 gives a tick every cycle.
- Config load:
  - cfg_load_i = 1 captures all cfg_* into the shadow registers and sets pending.
  - A later load before apply overwrites the shadow; the last load wins.
- Config apply:
  - Occurs on any cycle with FSM in IDLE and pending = 1.
  - Active sel/divider and gen_phase_o/gen_amplitude_o take the shadow values on that edge; pending clears.
  - If load and apply fall in the same cycle, the newly loaded value is applied.
  - Apply also resets the divider count to 0.
- FSM states:
  - IDLE:
    - Tick (and no apply this cycle) → STROBE.
    - Tick in an apply cycle is discarded.
  - STROBE:
    - gen_next_data_strobe_o = 1 for exactly this one cycle.
    - sel = 3 → OUTPUT with mute; otherwise → WAIT with the wait counter cleared.
  - WAIT:
    - Monitors only the valid strobe of the selected channel.
    - Selected valid = 1 → capture that channel's data into the output holding register → OUTPUT.
    - Wait counter reaches TIMEOUT → set timeout_o → IDLE, with no data_valid_strobe_o.
  - OUTPUT:
    - data_o is updated (0 when mute) and data_valid_strobe_o = 1 for one cycle → IDLE.
- Latency: tick (IDLE) → strobe 1 cycle later → data_valid_strobe_o 2 cycles after the generator's valid pulse is seen.
  - Mute: data_valid_strobe_o asserts 2 cycles after the strobe.
- gen_phase_o and gen_amplitude_o never change while busy_o = 1.
- Overrun: a tick while FSM ≠ IDLE sets overrun_o; that tick is dropped (not queued).
- Valid strobes of unselected channels, and any valid while not in WAIT, are ignored.
- data_o holds its value between strobes.
- Reset mid-sample returns the FSM to IDLE immediately; any in-flight generator result is ignored.
- The block performs no arithmetic on samples; widths pass through unchanged.

Test Plan:
- Reset, then load phase=8, amp=100, sel=1, div=9, enable=1:
  - Config applied on the next cycle; cfg_pending_o 1→0.
  - gen_next_data_strobe_o pulses every 10 cycles.
  - Stubbed generator returning triangle=37 one cycle after the strobe → data_o=37 with data_valid_strobe_o 2 cycles after the valid.
- Mid-sample reconfiguration: load amp=50 while busy_o=1:
  - gen_amplitude_o stays 100 until FSM returns to IDLE, then becomes 50.
  - cfg_pending_o stays high while busy.
- Channel filtering: sel=2; stub pulses sawtooth_valid(=5) then square_valid(=-128):
  - data_o=-128, exactly one data_valid_strobe_o.
- Timeout: sel=0; stub never asserts sawtooth_valid, TIMEOUT=15:
  - FSM returns to IDLE 15 cycles after entering WAIT; timeout_o=1 and stays 1.
  - No data strobe; the next tick proceeds normally.
- Overrun and mute:
  - div=0, sel=3 → strobe/output cycle of 3 cycles; ticks during busy set overrun_o=1.
  - data_o=0 on each data_valid_strobe_o.
- Reset in WAIT with a valid arriving in the same cycle:
  - All outputs 0 on the next cycle, no data_valid_strobe_o, sticky flags cleared.
